adder_serial_ctrl: RTL and testbench



---
 rtl/adder_ctrl_pkg.sv | 18 +
 rtl/adder.sv | 13 +
 rtl/adder_serial_ctrl.sv | 133 +++++++++++++
 tb/tb_adder_serial_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_ctrl_pkg.sv
// Shared types and defaults for the digit-serial adder sequencer.
package adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEF_DATA_W   = 4;
  localparam int unsigned DEF_N_SLICES = 2;

  // Index width that never collapses to zero bits.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder.sv
// Shared DATA_W-bit slice adder: X = A + B + Carry, with carry out in X[DATA_W].
module adder #(
  parameter int unsigned DATA_W = 4
) (
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic              Carry,
  output logic [DATA_W:0]   X
);

  assign X = {1'b0, A} + {1'b0, B} + (DATA_W+1)'(Carry);

endmodule

// File: rtl/adder_serial_ctrl.sv
// Digit-serial W-bit adder that reuses one DATA_W-bit adder over N_SLICES passes.
// Define ADDER_SUB_EN to add a `sub` input selecting A-B instead of A+B.
module adder_serial_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned N_SLICES = DEF_N_SLICES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W*N_SLICES-1:0] A,
  input  logic [DATA_W*N_SLICES-1:0] B,
`ifdef ADDER_SUB_EN
  input  logic                       sub,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W*N_SLICES:0]   X,
  output logic                       busy
);

  localparam int unsigned W     = DATA_W * N_SLICES;
  localparam int unsigned CNT_W = min1_clog2(N_SLICES);
  localparam int unsigned IDX_W = min1_clog2(W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SLICES - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       a_q, b_q, result_q, result_d;
  logic               sub_q, sub_c, carry_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   base_c;
  logic [DATA_W-1:0]  a_slice_c, b_slice_c;
  logic [DATA_W:0]    sum_c;
  logic               accept_c, step_c, last_c;

`ifdef ADDER_SUB_EN
  assign sub_c = sub;
`else
  assign sub_c = 1'b0;
`endif

  // Slice selection for the current pass; subtraction inverts B and seeds carry=1.
  assign base_c    = IDX_W'(cnt_q) * IDX_W'(DATA_W);
  assign a_slice_c = a_q[base_c +: DATA_W];
  assign b_slice_c = b_q[base_c +: DATA_W] ^ {DATA_W{sub_q}};

  adder #(.DATA_W(DATA_W)) u_adder (
    .A    (a_slice_c),
    .B    (b_slice_c),
    .Carry(carry_q),
    .X    (sum_c)
  );

  always_comb begin
    result_d = result_q;
    result_d[base_c +: DATA_W] = sum_c[DATA_W-1:0];
  end

  // Next-state and per-cycle control strobes.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    step_c   = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_c = 1'b1;
          state_d  = RUN;
        end
      end
      RUN: begin
        step_c = 1'b1;
        if (cnt_q == LAST_CNT) begin
          last_c  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with registered handshake/status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Operand capture, per-pass accumulation and final result load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      X        <= '0;
    end else if (accept_c) begin
      a_q     <= A;
      b_q     <= B;
      sub_q   <= sub_c;
      carry_q <= sub_c;
      cnt_q   <= '0;
    end else if (step_c) begin
      result_q <= result_d;
      carry_q  <= sum_c[DATA_W];
      if (last_c) begin
        cnt_q <= '0;
        X     <= {sum_c[DATA_W], result_d};
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_adder_serial_ctrl.sv
// Scoreboard bench for adder_serial_ctrl at default, 8x1 and 2x4 geometries.
module tb_adder_serial_ctrl;

  localparam int unsigned W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default geometry (4x2)
  logic in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [W-1:0] a = '0, b = '0;
  logic [W:0]   x;
  // 8x1
  logic v8 = 1'b0, or8 = 1'b1;
  logic r8, ov8, busy8;
  logic [7:0] a8 = '0, b8 = '0;
  logic [8:0] x8;
  // 2x4
  logic v2 = 1'b0, or2 = 1'b1;
  logic r2, ov2, busy2;
  logic [7:0] a2 = '0, b2 = '0;
  logic [8:0] x2;
`ifdef ADDER_SUB_EN
  logic sub = 1'b0, s8 = 1'b0, s2 = 1'b0;
`endif

  int checks = 0;
  int fails  = 0;
  logic [W:0] sb_q[$];

  adder_serial_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b),
`ifdef ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .X(x), .busy(busy)
  );

  adder_serial_ctrl #(.DATA_W(8), .N_SLICES(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(r8),
    .A(a8), .B(b8),
`ifdef ADDER_SUB_EN
    .sub(s8),
`endif
    .out_valid(ov8), .out_ready(or8), .X(x8), .busy(busy8)
  );

  adder_serial_ctrl #(.DATA_W(2), .N_SLICES(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(r2),
    .A(a2), .B(b2),
`ifdef ADDER_SUB_EN
    .sub(s2),
`endif
    .out_valid(ov2), .out_ready(or2), .X(x2), .busy(busy2)
  );

  function automatic logic [W:0] model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                       input logic si);
    if (si) return {ai >= bi, ai - bi};
    return {1'b0, ai} + {1'b0, bi};
  endfunction

  task automatic send(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic si);
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_wait: in_ready=%0b required 1", in_ready);
    end
    in_valid = 1'b1;
    a = ai;
    b = bi;
`ifdef ADDER_SUB_EN
    sub = si;
`endif
    sb_q.push_back(model(ai, bi, si));
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  task automatic collect(input string name);
    int n = 0;
    logic [W:0] e;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || sb_q.size() == 0) begin
      fails++;
      $display("FAIL %s_timeout: out_valid=%0b queued=%0d required valid and 1 queued",
               name, out_valid, sb_q.size());
    end else begin
      e = sb_q.pop_front();
      if (x !== e) begin
        fails++;
        $display("FAIL %s: X=%h required %h", name, x, e);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b000 || x !== '0) begin
      fails++;
      $display("FAIL reset_vals: rdy/vld/busy=%b X=%h required 000 and 0",
               {in_ready, out_valid, busy}, x);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, r8, r2} !== 3'b111) begin
      fails++;
      $display("FAIL reset_ready: in_ready(all)=%b required 111", {in_ready, r8, r2});
    end
  endtask

  task automatic test_basic;
    logic [W:0] e;
    out_ready = 1'b1;
    send(8'h35, 8'h4A, 1'b0);
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b010) begin
      fails++;
      $display("FAIL basic_run1: rdy/busy/vld=%b required 010", {in_ready, busy, out_valid});
    end
    @(posedge clk); #1;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b010) begin
      fails++;
      $display("FAIL basic_run2: rdy/busy/vld=%b required 010", {in_ready, busy, out_valid});
    end
    @(posedge clk); #1;
    e = sb_q.pop_front();
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b011 || x !== e) begin
      fails++;
      $display("FAIL basic_done: rdy/busy/vld=%b X=%h required 011 X=%h",
               {in_ready, busy, out_valid}, x, e);
    end
    @(posedge clk); #1;
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      fails++;
      $display("FAIL basic_idle: rdy/busy/vld=%b required 100", {in_ready, busy, out_valid});
    end
  endtask

  task automatic test_carry;
    send(8'hFF, 8'h01, 1'b0);
    collect("carry_ff_01");
    send(8'hFF, 8'hFF, 1'b0);
    collect("carry_ff_ff");
    send(8'h00, 8'h00, 1'b0);
    collect("carry_zero");
  endtask

  task automatic test_backpressure;
    logic [W:0] e;
    int n = 0;
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b0);
    while (!out_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_valid = 1'b1;
        a = 8'h01;
        b = 8'h01;
      end
      checks++;
      if (out_valid !== 1'b1 || x !== e || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: vld=%0b rdy=%0b X=%h required 1 0 %h",
                 i, out_valid, in_ready, x, e);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || x !== e) begin
      fails++;
      $display("FAIL bp_release: vld=%0b rdy=%0b X=%h required 0 1 %h",
               out_valid, in_ready, x, e);
    end
    send(8'h01, 8'h01, 1'b0);
    collect("bp_next");
  endtask

  task automatic test_reset_mid_run;
    send(8'h55, 8'h22, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b000 || x !== '0) begin
      fails++;
      $display("FAIL abort_async: vld/busy/rdy=%b X=%h required 000 and 0",
               {out_valid, busy, in_ready}, x);
    end
    void'(sb_q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL abort_no_result%0d: out_valid=%0b required 0", i, out_valid);
      end
    end
    send(8'h0F, 8'h01, 1'b0);
    collect("abort_next");
  endtask

`ifdef ADDER_SUB_EN
  task automatic test_sub;
    send(8'h10, 8'h01, 1'b1);
    collect("sub_10_01");
    send(8'h01, 8'h02, 1'b1);
    collect("sub_01_02");
    send(8'h10, 8'h01, 1'b0);
    collect("sub0_add");
  endtask
`endif

  task automatic test_single_slice;
    v8 = 1'b1;
    a8 = 8'h80;
    b8 = 8'h80;
    checks++;
    if (r8 !== 1'b1) begin
      fails++;
      $display("FAIL s1_ready: in_ready=%0b required 1", r8);
    end
    @(posedge clk); #1;
    v8 = 1'b0;
    checks++;
    if (ov8 !== 1'b0 || r8 !== 1'b0) begin
      fails++;
      $display("FAIL s1_run: vld=%0b rdy=%0b required 0 0", ov8, r8);
    end
    @(posedge clk); #1;
    checks++;
    if (ov8 !== 1'b1 || x8 !== 9'h100 || busy8 !== 1'b1) begin
      fails++;
      $display("FAIL s1_done: vld=%0b busy=%0b X=%h required 1 1 100", ov8, busy8, x8);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random_2x4;
    logic [8:0] q2[$];
    logic [8:0] e;
    int n;
    for (int i = 0; i < 200; i++) begin
      n = 0;
      while (!r2 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      v2 = 1'b1;
      a2 = 8'($urandom);
      b2 = 8'($urandom);
      q2.push_back({1'b0, a2} + {1'b0, b2});
      @(posedge clk); #1;
      v2 = 1'b0;
      n = 0;
      while (!ov2 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      e = q2.pop_front();
      checks++;
      if (ov2 !== 1'b1 || busy2 !== 1'b1 || x2 !== e) begin
        fails++;
        $display("FAIL rand2x4_%0d: vld=%0b busy=%0b X=%h required 1 1 %h",
                 i, ov2, busy2, x2, e);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_backpressure();
    test_reset_mid_run();
`ifdef ADDER_SUB_EN
    test_sub();
`endif
    test_single_slice();
    test_random_2x4();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
